// File: rtl/cpu_pkg.sv
// Shared widths and the fetch FSM state type for the fetch stage and the control decoder.
package cpu_pkg;

  localparam int OPCODE_W = 7;
  localparam int K_W      = 8;
  localparam int PC_W     = 8;
  localparam int INSTR_W  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Sequential successor; 8'hFF wraps to 8'h00 by width truncation.
  function automatic logic [PC_W-1:0] pc_next_seq(input logic [PC_W-1:0] cur);
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Fetch program counter: load (jump), increment with 8-bit wrap, async reset to RESET_VAL.
module pc_counter
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= pc_next_seq(value);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with ack watchdog; define FETCH_PREFETCH_EN to add a one-entry
// prefetch buffer that keeps instr_valid continuous on sequential flow.
//
// state | meaning
// IDLE  | after reset, no request outstanding
// FETCH | imem_req high for fetch_pc, waiting for imem_ack
// HOLD  | opcode/k/pc valid, waiting for exec_ready
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = 8'h00,
  parameter int              IMEM_LAT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_data,
  output logic [OPCODE_W-1:0] opcode,
  output logic [K_W-1:0]      k,
  output logic                instr_valid,
  input  logic                exec_ready,
  input  logic                LP,
  output logic [PC_W-1:0]     pc,
  output logic                imem_timeout
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] fetch_pc;
  logic            accept;
  logic            fetch_ack;
  logic            pc_load;
  logic            pc_inc;

  assign accept  = instr_valid & exec_ready;
  assign pc_load = accept & LP;
  assign pc_inc  = accept & ~LP;

`ifdef FETCH_PREFETCH_EN
  logic                pf_valid;
  logic                pf_discard;
  logic                pf_ack;
  logic [OPCODE_W-1:0] pf_opcode;
  logic [K_W-1:0]      pf_k;

  assign pf_ack    = (state == HOLD) & ~pf_valid & imem_ack;
  assign fetch_ack = (state == FETCH) & ~pf_discard & imem_ack;
`else
  assign fetch_ack = (state == FETCH) & imem_ack;
`endif

  // fetch_pc mirrors pc while in HOLD, so its increment equals pc+1 on sequential accept.
  pc_counter #(
    .RESET_VAL(RESET_PC)
  ) u_fetch_pc (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (k),
    .value    (fetch_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  state_next = FETCH;
      FETCH: if (fetch_ack) state_next = HOLD;
      HOLD: begin
        if (accept) begin
`ifdef FETCH_PREFETCH_EN
          if (LP || !(pf_valid || pf_ack)) state_next = FETCH;
`else
          state_next = FETCH;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
`ifdef FETCH_PREFETCH_EN
    // While a discarded prefetch is still owed an ack, the new request waits.
    if (state == FETCH && !pf_discard) imem_req = 1'b1;
    if (state == HOLD && !pf_valid) begin
      imem_req  = 1'b1;
      imem_addr = pc_next_seq(pc);
    end
`else
    if (state == FETCH) imem_req = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode      <= '0;
      k           <= '0;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
    end else if (fetch_ack) begin
      opcode      <= imem_data[INSTR_W-1 -: OPCODE_W];
      k           <= imem_data[K_W-1:0];
      pc          <= fetch_pc;
      instr_valid <= 1'b1;
    end else if (accept) begin
`ifdef FETCH_PREFETCH_EN
      if (!LP && pf_valid) begin
        opcode <= pf_opcode;
        k      <= pf_k;
        pc     <= pc_next_seq(pc);
      end else if (!LP && pf_ack) begin
        opcode <= imem_data[INSTR_W-1 -: OPCODE_W];
        k      <= imem_data[K_W-1:0];
        pc     <= pc_next_seq(pc);
      end else begin
        instr_valid <= 1'b0;
      end
`else
      instr_valid <= 1'b0;
`endif
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pf_valid   <= 1'b0;
      pf_discard <= 1'b0;
      pf_opcode  <= '0;
      pf_k       <= '0;
    end else begin
      if (pf_ack) begin
        pf_opcode <= imem_data[INSTR_W-1 -: OPCODE_W];
        pf_k      <= imem_data[K_W-1:0];
      end
      if (accept) begin
        pf_valid <= 1'b0;
      end else if (pf_ack) begin
        pf_valid <= 1'b1;
      end
      // A jump that lands while the prefetch is in flight owes the memory one ack to drop.
      if (accept && LP && state == HOLD && !pf_valid && !imem_ack) begin
        pf_discard <= 1'b1;
      end else if (state == FETCH && pf_discard && imem_ack) begin
        pf_discard <= 1'b0;
      end
    end
  end
`endif

  generate
    if (IMEM_LAT_MAX > 0) begin : g_wd
      localparam int WD_W = $clog2(IMEM_LAT_MAX + 1);
      logic [WD_W-1:0] wd_cnt;
      logic            wd_run;

      assign wd_run = (state == FETCH) & imem_req;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wd_cnt       <= '0;
          imem_timeout <= 1'b0;
        end else if (!wd_run || imem_ack) begin
          wd_cnt <= '0;
        end else if (wd_cnt != WD_W'(IMEM_LAT_MAX)) begin
          wd_cnt <= wd_cnt + 1'b1;
          if (wd_cnt == WD_W'(IMEM_LAT_MAX - 1)) imem_timeout <= 1'b1;
        end
      end
    end else begin : g_no_wd
      assign imem_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                imem_req;
  logic [PC_W-1:0]     imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_data;
  logic [OPCODE_W-1:0] opcode;
  logic [K_W-1:0]      k;
  logic                instr_valid;
  logic                exec_ready;
  logic                LP;
  logic [PC_W-1:0]     pc;
  logic                imem_timeout;

  int total = 0;
  int bad   = 0;

  logic [INSTR_W-1:0] mem [256];
  int                 lat;
  logic               model_en;
  logic               m_ack = 1'b0;
  logic [INSTR_W-1:0] m_data = '0;
  logic               pending = 1'b0;
  logic [PC_W-1:0]    paddr = '0;
  int                 cnt = 0;
  logic               f_ack;
  logic [INSTR_W-1:0] f_data;

  assign imem_ack  = model_en ? m_ack  : f_ack;
  assign imem_data = model_en ? m_data : f_data;

  fetch_stage #(
    .RESET_PC     (8'h00),
    .IMEM_LAT_MAX (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .opcode       (opcode),
    .k            (k),
    .instr_valid  (instr_valid),
    .exec_ready   (exec_ready),
    .LP           (LP),
    .pc           (pc),
    .imem_timeout (imem_timeout)
  );

  always #5 clk = ~clk;

  // Memory: one ack per request, lat cycles after the request's first cycle.
  always @(negedge clk) begin
    if (reset || !model_en) begin
      m_ack   = 1'b0;
      pending = 1'b0;
      cnt     = 0;
    end else begin
      if (m_ack) begin
        m_ack   = 1'b0;
        pending = 1'b0;
      end
      if (!pending && imem_req) begin
        pending = 1'b1;
        paddr   = imem_addr;
        cnt     = 0;
      end
      if (pending && !m_ack) begin
        cnt++;
        if (cnt == lat + 1) begin
          m_ack  = 1'b1;
          m_data = mem[paddr];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset      = 1'b1;
    exec_ready = 1'b0;
    LP         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic accept_instr(input logic lp);
    exec_ready = 1'b1;
    LP         = lp;
    step(1);
    exec_ready = 1'b0;
    LP         = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      step(1);
      n++;
    end
    if (!instr_valid) chk({tag, "_valid_timeout"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic check_instr(input string tag, input logic [PC_W-1:0] a);
    logic [INSTR_W-1:0] w;
    w = mem[a];
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_op"}, {25'd0, opcode}, {25'd0, w[14:8]});
    chk({tag, "_k"}, {24'd0, k}, {24'd0, w[7:0]});
    chk({tag, "_pc"}, {24'd0, pc}, {24'd0, a});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   req_seen;
    logic changed;

    for (int a = 0; a < 256; a++) begin
      logic [7:0] av;
      av     = a[7:0];
      mem[a] = {av[6:0] ^ 7'h2A, ~av};
    end
    mem[8'h00] = 15'h0205;
    mem[8'h01] = {7'h03, 8'h40};
    mem[8'h03] = {7'h33, 8'h80};
    mem[8'h40] = {7'h10, 8'hFF};
    mem[8'hFF] = {7'h21, 8'h12};

    reset      = 1'b1;
    model_en   = 1'b1;
    lat        = 1;
    exec_ready = 1'b0;
    LP         = 1'b0;
    f_ack      = 1'b0;
    f_data     = '0;

    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_op", {25'd0, opcode}, 32'h00);
    chk("rst_k", {24'd0, k}, 32'h00);
    chk("rst_timeout", {31'd0, imem_timeout}, 32'd0);
    reset = 1'b0;

    // First fetch: address in cycle 1, instruction valid in cycle 3.
    step(1);
    chk("c1_req", {31'd0, imem_req}, 32'd1);
    chk("c1_addr", {24'd0, imem_addr}, 32'h00);
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    chk("c2_valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    chk("c3_valid", {31'd0, instr_valid}, 32'd1);
    chk("c3_op", {25'd0, opcode}, 32'h02);
    chk("c3_k", {24'd0, k}, 32'h05);
    chk("c3_pc", {24'd0, pc}, 32'h00);

    req_seen = 0;
    changed  = 1'b0;
    repeat (10) begin
      step(1);
      if (opcode !== 7'h02 || k !== 8'h05 || pc !== 8'h00 || instr_valid !== 1'b1) changed = 1'b1;
      if (imem_req) req_seen++;
    end
    chk("stall_hold", {31'd0, changed}, 32'd0);
`ifndef FETCH_PREFETCH_EN
    chk("stall_no_req", req_seen, 32'd0);
`endif

    accept_instr(1'b0);
`ifndef FETCH_PREFETCH_EN
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("seq_addr", {24'd0, imem_addr}, 32'h01);
`endif
    wait_valid("seq", 10);
    check_instr("seq", 8'h01);

    accept_instr(1'b1);
`ifndef FETCH_PREFETCH_EN
    chk("jmp_addr", {24'd0, imem_addr}, 32'h40);
`endif
    wait_valid("jmp", 10);
    check_instr("jmp", 8'h40);

    accept_instr(1'b1);
    wait_valid("jmp_ff", 10);
    check_instr("jmp_ff", 8'hFF);

    accept_instr(1'b0);
`ifndef FETCH_PREFETCH_EN
    chk("wrap_addr", {24'd0, imem_addr}, 32'h00);
`endif
    wait_valid("wrap", 10);
    check_instr("wrap", 8'h00);

    // Reset during an outstanding request; a late ack lands while in IDLE.
    lat = 5;
    do_reset;
    step(1);
    chk("abn_req_before", {31'd0, imem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abn_req_async", {31'd0, imem_req}, 32'd0);
    model_en = 1'b0;
    step(2);
    reset  = 1'b0;
    f_ack  = 1'b1;
    f_data = 15'h7ABC;
    step(1);
    f_ack    = 1'b0;
    model_en = 1'b1;
    lat      = 1;
    chk("abn_valid", {31'd0, instr_valid}, 32'd0);
    chk("abn_req", {31'd0, imem_req}, 32'd1);
    chk("abn_addr", {24'd0, imem_addr}, 32'h00);
    wait_valid("abn", 10);
    check_instr("abn", 8'h00);

    // Watchdog: 15 FETCH cycles without ack.
    lat = 30;
    do_reset;
    step(15);
    chk("wd_before", {31'd0, imem_timeout}, 32'd0);
    step(1);
    chk("wd_fire", {31'd0, imem_timeout}, 32'd1);
    chk("wd_req_kept", {31'd0, imem_req}, 32'd1);
    wait_valid("wd", 40);
    chk("wd_sticky", {31'd0, imem_timeout}, 32'd1);
    check_instr("wd", 8'h00);

`ifdef FETCH_PREFETCH_EN
    lat = 0;
    do_reset;
    step(2);
    chk("pf_first_valid", {31'd0, instr_valid}, 32'd1);
    chk("pf_first_pc", {24'd0, pc}, 32'h00);
    step(2);
    exec_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("pf_b2b_valid", {31'd0, instr_valid}, 32'd1);
      chk("pf_b2b_pc", {24'd0, pc}, i);
    end
    exec_ready = 1'b0;
    lat        = 3;
    accept_instr(1'b1);
    chk("pf_jmp_valid", {31'd0, instr_valid}, 32'd0);
    chk("pf_jmp_req_held", {31'd0, imem_req}, 32'd0);
    wait_valid("pf_jmp", 20);
    check_instr("pf_jmp", 8'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 Parameter: IMEM_LAT_MAX, 15, watchdog limit in cycles for imem_ack; 0 disables the watchdog.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: imem_req  out  1  instruction-memory read request.
REQ-006 Port: imem_addr  out  8  read address, equal to the PC being fetched.
REQ-007 Port: imem_ack  in  1  read-data-valid strobe, one cycle per request.
REQ-008 Port: imem_data  in  15  instruction word: [14:8] opcode, [7:0] K.
REQ-009 Port: opcode  out  7  held opcode to the control decoder.
REQ-010 Port: k  out  8  held literal K, also the jump target.
REQ-011 Port: instr_valid  out  1  opcode/k hold a valid instruction.
REQ-012 Port: exec_ready  in  1  execute stage accepts the current instruction this cycle.
REQ-013 Port: LP  in  1  jump-taken flag from control, sampled only on accept.
REQ-014 Port: pc  out  8  address of the instruction on opcode/k.
REQ-015 Port: imem_timeout  out  1  sticky flag set when the watchdog expires.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and HOLD; reset enters IDLE, and IDLE moves to FETCH on the next edge.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc, both held stable until imem_ack.
REQ-018 On imem_ack in FETCH, the stage SHALL register opcode=imem_data[14:8] and k=imem_data[7:0], go to HOLD, and assert instr_valid the following cycle (1-cycle latency).
REQ-019 Accept SHALL be defined as instr_valid & exec_ready.
REQ-020 On accept, next fetch_pc SHALL be k if LP=1, else pc+1 modulo 256 (8'hFF wraps to 8'h00); instr_valid drops and the FSM returns to FETCH, with imem_req asserted the next cycle.
REQ-021 In HOLD without accept, opcode, k, pc and instr_valid SHALL stay unchanged.
REQ-022 imem_ack SHALL be ignored in IDLE and in any state with no request outstanding.
REQ-023 The watchdog SHALL count FETCH cycles without ack; on reaching IMEM_LAT_MAX it sets imem_timeout and the request stays asserted.

Reset
REQ-024 Asynchronous reset SHALL immediately force: state=IDLE, pc=fetch_pc=RESET_PC, imem_req=0, instr_valid=0, opcode=0, k=0, imem_timeout=0, watchdog=0, prefetch buffer empty with the discard flag clear.
REQ-025 A request outstanding at reset SHALL be abandoned, and its late ack SHALL be ignored per REQ-022.

Configuration
REQ-026 The macro FETCH_PREFETCH_EN SHALL control prefetch.
REQ-027 With FETCH_PREFETCH_EN defined, in HOLD the stage SHALL fetch pc+1 into a one-entry prefetch buffer.
REQ-028 On accept with LP=0 and the buffer full, the buffer SHALL move to opcode/k with instr_valid kept at 1, giving back-to-back issue.
REQ-029 On accept with LP=0 and the prefetch still in flight, the stage SHALL wait for that ack and then issue.
REQ-030 On accept with LP=1, the stage SHALL discard the buffer; an in-flight prefetch ack SHALL be dropped via a discard flag, after which the stage fetches from k.
REQ-031 Without FETCH_PREFETCH_EN, no buffer logic SHALL exist and behaviour SHALL be exactly REQ-016 to REQ-023.

Structure
REQ-032 Package cpu_pkg SHALL hold OPCODE_W=7, K_W=8, PC_W=8, INSTR_W=15 and the fetch state enum; the control decoder shares these widths.
REQ-033 Sub-module pc_counter (load/increment/wrap, async reset) SHALL be instantiated once for fetch_pc.

Verification
REQ-034 Reset with ack latency 1 and imem[0]=15'h0205 -> imem_addr=0 in cycle 1, instr_valid in cycle 3 with opcode=7'h02, k=8'h05, pc=0.
REQ-035 Accept at pc=8'hFF with LP=0 -> next imem_addr=8'h00.
REQ-036 Accept with LP=1, k=8'h40 (JMP) -> next imem_addr=8'h40 and pc=8'h40 on the next valid instruction.
REQ-037 exec_ready=0 for 10 cycles -> opcode/k/pc stable and no new imem_req without prefetch.
REQ-038 Reset asserted while imem_req=1, ack arriving one cycle after release -> ack ignored and fetch restarts at RESET_PC.
REQ-039 FETCH_PREFETCH_EN with 3 sequential accepts -> instr_valid continuous; a jump taken with the prefetch in flight -> the stale ack is dropped and the instruction at k is issued.
